// File: rtl/led_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : led_pkg                                                  |
// | Description : Shared definitions for the LED status encoder: LED mode  |
// |               codes consumed by the LED driver, the priority FSM state |
// |               encoding and a helper that sizes counters.               |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package led_pkg;

    // LED mode codes on the driver's i_ctrl input; 2'b11 is never produced
    localparam logic [1:0] LED_ON    = 2'b00;
    localparam logic [1:0] LED_OFF   = 2'b01;
    localparam logic [1:0] LED_BLINK = 2'b10;

    // Priority FSM state encoding
    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_ON  = 2'd1;
    localparam logic [1:0] S_ACT = 2'd2;
    localparam logic [1:0] S_FLT = 2'd3;

    // Bits needed to hold values 0..max_value, never less than one bit
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_blink_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : led_blink_gen                                            |
// | Description : Square-wave blink generator. Counts HALF_MS milliseconds |
// |               per half-period and toggles o_phase on each wrap.        |
// |               Millisecond timing is derived from the shared prescaler  |
// |               count; a restart re-aligns the millisecond boundary to   |
// |               the restart cycle so the first half-period is full.      |
// | Ports       : clk, rst_n  clock / async active-low reset               |
// |               i_pre_cnt   shared prescaler count (0..CLK_PER_MS-1)     |
// |               i_restart   sync restart: count cleared, phase forced 0  |
// |               o_phase     blink phase, 0 = lit half                    |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module led_blink_gen
    import led_pkg::*;
#(
    parameter int PRE_W   = 16,
    parameter int HALF_MS = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PRE_W-1:0] i_pre_cnt,
    input  logic             i_restart,
    output logic             o_phase
);

    localparam int                 c_cnt_w    = cnt_width(HALF_MS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(HALF_MS - 1);

    logic [PRE_W-1:0]   r_ofs;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_phase;
    logic               w_tick;

    // The local millisecond tick fires when the shared prescaler returns
    // to the value it held on the restart cycle, i.e. exactly one full
    // millisecond after each restart and every millisecond thereafter.
    assign w_tick = (i_pre_cnt == r_ofs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ofs   <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_restart) begin
            r_ofs   <= i_pre_cnt;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/led_status_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : led_status_encoder                                       |
// | Description : Converts raw board status into the LED driver's 2-bit    |
// |               mode code and blink waveform. Contains the ms prescaler, |
// |               slow (activity) and fast (fault) blink generators, the   |
// |               activity pulse stretcher, the fault latch and a fixed-   |
// |               priority FSM (fault > activity > run > off).             |
// | Ports       : clk, rst_n       clock / async active-low reset          |
// |               i_run            level, module in run mode               |
// |               i_fault          level, fault present                    |
// |               i_fault_clr      pulse, operator fault acknowledge       |
// |               i_comm_act       pulse, one per received frame           |
// |               o_ctrl           LED mode 00 ON, 01 OFF, 10 BLINK        |
// |               o_freq           blink waveform, 0 = lit, 1 = dark       |
// |               o_fault_latched  latched fault flag                      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module led_status_encoder
    import led_pkg::*;
#(
    parameter int CLK_PER_MS   = 50000,
    parameter int SLOW_HALF_MS = 500,
    parameter int FAST_HALF_MS = 250,
    parameter int ACT_HOLD_MS  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_run,
    input  logic       i_fault,
    input  logic       i_fault_clr,
    input  logic       i_comm_act,
    output logic [1:0] o_ctrl,
    output logic       o_freq,
    output logic       o_fault_latched
);

    localparam int                 c_pre_w    = cnt_width(CLK_PER_MS - 1);
    localparam int                 c_act_w    = cnt_width(ACT_HOLD_MS);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(CLK_PER_MS - 1);
    localparam logic [c_act_w-1:0] c_act_hold = c_act_w'(ACT_HOLD_MS);

    logic [c_pre_w-1:0] r_pre_cnt;
    logic [c_act_w-1:0] r_act_cnt;
    logic               r_fault_latched;
    logic [1:0]         r_state;
    logic [1:0]         r_ctrl;
    logic               r_freq;

    logic               w_ms_tick;
    logic               w_act_active;
    logic [1:0]         w_next_state;
    logic               w_restart_slow;
    logic               w_restart_fast;
    logic               w_slow_phase;
    logic               w_fast_phase;
    logic [1:0]         w_ctrl;
    logic               w_freq;

    // Millisecond prescaler, shared by the stretcher and both generators
    assign w_ms_tick = (r_pre_cnt == c_pre_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_pre_cnt <= '0;
        else if (w_ms_tick) r_pre_cnt <= '0;
        else                r_pre_cnt <= r_pre_cnt + 1'b1;
    end

    // Activity stretcher: a frame pulse (re)loads the hold time, which wins
    // over a coincident decrement.
    assign w_act_active = (r_act_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_act_cnt <= '0;
        else if (i_comm_act)                 r_act_cnt <= c_act_hold;
        else if (w_ms_tick && w_act_active)  r_act_cnt <= r_act_cnt - 1'b1;
    end

    // Fault latch: a fault still present blocks the acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_fault_latched <= 1'b0;
        else if (i_fault)     r_fault_latched <= 1'b1;
        else if (i_fault_clr) r_fault_latched <= 1'b0;
    end

    // Priority FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_OFF;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_OFF;
        if (r_fault_latched)   w_next_state = S_FLT;
        else if (w_act_active) w_next_state = S_ACT;
        else if (i_run)        w_next_state = S_ON;
    end

    // Each generator restarts only when its own blink state is entered
    assign w_restart_slow = (w_next_state == S_ACT) && (r_state != S_ACT);
    assign w_restart_fast = (w_next_state == S_FLT) && (r_state != S_FLT);

    led_blink_gen #(
        .PRE_W   (c_pre_w),
        .HALF_MS (SLOW_HALF_MS)
    ) u_slow_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_pre_cnt (r_pre_cnt),
        .i_restart (w_restart_slow),
        .o_phase   (w_slow_phase)
    );

    led_blink_gen #(
        .PRE_W   (c_pre_w),
        .HALF_MS (FAST_HALF_MS)
    ) u_fast_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_pre_cnt (r_pre_cnt),
        .i_restart (w_restart_fast),
        .o_phase   (w_fast_phase)
    );

    // Output decode from the current state, registered
    always_comb begin
        w_ctrl = LED_OFF;
        w_freq = 1'b1;
        case (r_state)
            S_OFF: w_ctrl = LED_OFF;
            S_ON:  w_ctrl = LED_ON;
            S_ACT: begin
                w_ctrl = LED_BLINK;
                w_freq = w_slow_phase;
            end
            S_FLT: begin
                w_ctrl = LED_BLINK;
                w_freq = w_fast_phase;
            end
            default: begin
                w_ctrl = LED_OFF;
                w_freq = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= LED_OFF;
            r_freq <= 1'b1;
        end else begin
            r_ctrl <= w_ctrl;
            r_freq <= w_freq;
        end
    end

    assign o_ctrl          = r_ctrl;
    assign o_freq          = r_freq;
    assign o_fault_latched = r_fault_latched;

endmodule
`default_nettype wire

// File: tb/tb_led_status_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_led_status_encoder                                    |
// | Description : Self-checking bench for led_status_encoder with a cycle  |
// |               model of the status rules plus directed literal checks.  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_led_status_encoder;

    localparam int N    = 4;
    localparam int SLOW = 3;
    localparam int FAST = 1;
    localparam int HOLD = 5;

    localparam int M_OFF = 0;
    localparam int M_ON  = 1;
    localparam int M_ACT = 2;
    localparam int M_FLT = 3;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       i_run       = 1'b0;
    logic       i_fault     = 1'b0;
    logic       i_fault_clr = 1'b0;
    logic       i_comm_act  = 1'b0;
    logic [1:0] o_ctrl;
    logic       o_freq;
    logic       o_fault_latched;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_status_encoder #(
        .CLK_PER_MS   (N),
        .SLOW_HALF_MS (SLOW),
        .FAST_HALF_MS (FAST),
        .ACT_HOLD_MS  (HOLD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_run           (i_run),
        .i_fault         (i_fault),
        .i_fault_clr     (i_fault_clr),
        .i_comm_act      (i_comm_act),
        .o_ctrl          (o_ctrl),
        .o_freq          (o_freq),
        .o_fault_latched (o_fault_latched)
    );

    task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: ms ticks, stretch time, latch and mode by priority;
    // blink level is computed from time elapsed since entering the mode.
    int         m_pre      = 0;
    int         m_stretch  = 0;
    int         m_mode     = M_OFF;
    int         m_nxt      = M_OFF;
    int         m_slow_t0  = 0;
    int         m_fast_t0  = 0;
    int         m_cyc      = 0;
    bit         m_tick     = 1'b0;
    bit         m_latch    = 1'b0;
    bit         m_freq     = 1'b1;
    logic [1:0] m_ctrl     = 2'b01;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre     = 0;
            m_stretch = 0;
            m_mode    = M_OFF;
            m_latch   = 1'b0;
            m_ctrl    = 2'b01;
            m_freq    = 1'b1;
        end else begin
            m_cyc++;
            m_tick = (m_pre == N - 1);
            m_freq = 1'b1;
            case (m_mode)
                M_ON:    m_ctrl = 2'b00;
                M_ACT: begin
                    m_ctrl = 2'b10;
                    m_freq = (((m_cyc - 1 - m_slow_t0) / (SLOW * N)) % 2) != 0;
                end
                M_FLT: begin
                    m_ctrl = 2'b10;
                    m_freq = (((m_cyc - 1 - m_fast_t0) / (FAST * N)) % 2) != 0;
                end
                default: m_ctrl = 2'b01;
            endcase
            if (m_latch)             m_nxt = M_FLT;
            else if (m_stretch != 0) m_nxt = M_ACT;
            else if (i_run)          m_nxt = M_ON;
            else                     m_nxt = M_OFF;
            if (i_comm_act)                   m_stretch = HOLD;
            else if (m_tick && m_stretch > 0) m_stretch--;
            if (i_fault)          m_latch = 1'b1;
            else if (i_fault_clr) m_latch = 1'b0;
            if (m_nxt != m_mode) begin
                if (m_nxt == M_ACT) m_slow_t0 = m_cyc;
                if (m_nxt == M_FLT) m_fast_t0 = m_cyc;
            end
            m_mode = m_nxt;
            m_pre  = (m_pre + 1) % N;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("mdl_ctrl", o_ctrl, m_ctrl);
        check("mdl_freq", {1'b0, o_freq}, {1'b0, m_freq});
        check("mdl_flt", {1'b0, o_fault_latched}, {1'b0, m_latch});
        check("ctrl_not11", {1'b0, o_ctrl == 2'b11}, 2'b00);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_act();
        i_comm_act = 1'b1;
        @(negedge clk);
        i_comm_act = 1'b0;
    endtask

    initial begin
        // Reset and run
        cyc(3);
        check("rst_ctrl", o_ctrl, 2'b01);
        check("rst_freq", {1'b0, o_freq}, 2'b01);
        check("rst_flt", {1'b0, o_fault_latched}, 2'b00);
        rst_n = 1'b1;
        cyc(1);
        check("rel_ctrl", o_ctrl, 2'b01);
        i_run = 1'b1;
        cyc(1);
        check("run_1clk", o_ctrl, 2'b01);
        cyc(1);
        check("run_2clk", o_ctrl, 2'b00);

        // Single activity pulse
        cyc(3);
        pulse_act();
        cyc(1);
        check("act_lat", o_ctrl, 2'b00);
        cyc(1);
        check("act_ctrl", o_ctrl, 2'b10);
        check("act_lo", {1'b0, o_freq}, 2'b00);
        cyc(11);
        check("act_lo_end", {1'b0, o_freq}, 2'b00);
        cyc(1);
        check("act_hi", {1'b0, o_freq}, 2'b01);
        check("act_still", o_ctrl, 2'b10);
        cyc(8);
        check("act_done", o_ctrl, 2'b00);

        // Retrigger 12 clk after the first pulse
        cyc(4);
        pulse_act();
        cyc(11);
        pulse_act();
        cyc(1);
        check("retrig_lo", {1'b0, o_freq}, 2'b00);
        cyc(1);
        check("retrig_phase", {1'b0, o_freq}, 2'b01);
        cyc(16);
        check("retrig_ext", o_ctrl, 2'b10);
        cyc(4);
        check("retrig_done", o_ctrl, 2'b00);

        // Fault during activity
        cyc(3);
        pulse_act();
        cyc(5);
        i_fault = 1'b1;
        cyc(1);
        check("flt_latch", {1'b0, o_fault_latched}, 2'b01);
        cyc(2);
        check("flt_ctrl", o_ctrl, 2'b10);
        check("flt_lo1", {1'b0, o_freq}, 2'b00);
        cyc(3);
        check("flt_lo_end", {1'b0, o_freq}, 2'b00);
        cyc(1);
        check("flt_hi", {1'b0, o_freq}, 2'b01);
        cyc(4);
        check("flt_lo2", {1'b0, o_freq}, 2'b00);

        // Acknowledge while fault still present is ignored
        i_fault_clr = 1'b1;
        cyc(1);
        i_fault_clr = 1'b0;
        check("clr_blocked", {1'b0, o_fault_latched}, 2'b01);
        i_fault = 1'b0;
        cyc(6);
        check("clr_wait", {1'b0, o_fault_latched}, 2'b01);
        i_fault_clr = 1'b1;
        cyc(1);
        i_fault_clr = 1'b0;
        check("clr_ok", {1'b0, o_fault_latched}, 2'b00);
        cyc(2);
        check("clr_fallback", o_ctrl, 2'b00);

        // Simultaneous fault rise and acknowledge: set wins
        i_fault     = 1'b1;
        i_fault_clr = 1'b1;
        cyc(1);
        i_fault_clr = 1'b0;
        check("simul_set", {1'b0, o_fault_latched}, 2'b01);

        // Asynchronous reset in the middle of fault blinking
        cyc(10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", o_ctrl, 2'b01);
        check("arst_freq", {1'b0, o_freq}, 2'b01);
        check("arst_flt", {1'b0, o_fault_latched}, 2'b00);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("rst_relatch", {1'b0, o_fault_latched}, 2'b01);
        cyc(2);
        check("rst_flt_ctrl", o_ctrl, 2'b10);
        check("rst_flt_lo", {1'b0, o_freq}, 2'b00);
        cyc(4);
        check("rst_flt_hi", {1'b0, o_freq}, 2'b01);

        cyc(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
